im_loader: RTL and testbench

Synthesisable boot loader that streams a program into the SimpleMIPS instruction memory through its `im_write`/`im_addr`/`im_wdata` port, then releases the core to execute. Replaces hand-sequenced memory preload with a valid/ready word stream. Parametrised in data width, address width, program depth and base address, with overflow detection, a post-load settle interval and re-load support. Sits between the host/ROM stream source and the core top level.

---
 rtl/im_loader_pkg.sv | 18 +
 rtl/im_loader_if.sv | 27 ++
 rtl/im_loader_csum.sv | 29 ++
 rtl/im_loader.sv | 173 +++++++++++++++++
 tb/tb_im_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// Shared state encoding and default parameters for the im_loader boot loader.
package im_loader_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DEPTH      = 64;
  localparam int unsigned DEF_BASE_ADDR  = 1;
  localparam int unsigned DEF_SETTLE_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_ERROR  = 3'd4
  } im_loader_state_t;

endpackage

// File: rtl/im_loader_if.sv
// Word stream from the host/ROM source plus the instruction-memory write port.
interface im_loader_if
  import im_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              im_write;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready,
    input  im_write, im_addr, im_wdata
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready,
    output im_write, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader_csum.sv
// Running modulo-2**DATA_W sum of loaded words, compared against a trailer word.
module im_loader_csum
  import im_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] add_data,
  input  logic [DATA_W-1:0] cmp_data,
  output logic              match
);
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr)      sum_d = '0;
    else if (add) sum_d = sum_q + add_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign match = (sum_q == cmp_data);
endmodule

// File: rtl/im_loader.sv
// Streams a program into instruction memory over valid/ready, then releases the core.
// Define IM_LOADER_CHECKSUM_EN to treat the s_last word as a checksum trailer.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DEPTH      = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
  parameter int unsigned       SETTLE_CYC = DEF_SETTLE_CYC,
  localparam int unsigned      WC_W       = $clog2(DEPTH + 1),
  localparam int unsigned      SC_W       = $clog2(SETTLE_CYC + 1)
)(
  input  logic            clk,
  input  logic            rst,
  im_loader_if.slave      bus,
  input  logic            reload,
  output logic            core_run,
  output logic            done,
  output logic            error,
  output logic [WC_W-1:0] word_count
);

  // state     | meaning
  // ST_IDLE   | waiting for the first word of a load
  // ST_LOAD   | writing accepted words to consecutive addresses
  // ST_SETTLE | counting down before the core is released
  // ST_RUN    | core executing, load done
  // ST_ERROR  | overflow or checksum mismatch, core held

  im_loader_state_t  state_q, state_d;
  logic [WC_W-1:0]   word_count_q, word_count_d;
  logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              im_write_q, im_write_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [DATA_W-1:0] im_wdata_q, im_wdata_d;
  logic              core_run_q, core_run_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              accept, full;

  assign accept = bus.s_valid & s_ready_q;
  assign full   = (word_count_q == WC_W'(DEPTH));

`ifdef IM_LOADER_CHECKSUM_EN
  logic csum_clr, csum_add, csum_match;

  assign csum_clr = reload & ((state_q == ST_RUN) | (state_q == ST_ERROR));

  im_loader_csum #(.DATA_W(DATA_W)) u_csum (
    .clk      (clk),
    .rst      (rst),
    .clr      (csum_clr),
    .add      (csum_add),
    .add_data (bus.s_data),
    .cmp_data (bus.s_data),
    .match    (csum_match)
  );
`endif

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    settle_cnt_d = settle_cnt_q;
    im_write_d   = 1'b0;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    core_run_d   = core_run_q;
    done_d       = done_q;
    error_d      = error_q;
`ifdef IM_LOADER_CHECKSUM_EN
    csum_add     = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          state_d = ST_LOAD;
`ifdef IM_LOADER_CHECKSUM_EN
          // The trailer is checked against the words before it and never written.
          if (bus.s_last) begin
            if (csum_match) begin
              state_d      = ST_SETTLE;
              settle_cnt_d = SC_W'(SETTLE_CYC);
            end else begin
              state_d = ST_ERROR;
              error_d = 1'b1;
            end
          end else if (full) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            im_write_d   = 1'b1;
            im_addr_d    = BASE_ADDR + ADDR_W'(word_count_q);
            im_wdata_d   = bus.s_data;
            word_count_d = word_count_q + WC_W'(1);
            csum_add     = 1'b1;
          end
`else
          if (full) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else begin
            im_write_d   = 1'b1;
            im_addr_d    = BASE_ADDR + ADDR_W'(word_count_q);
            im_wdata_d   = bus.s_data;
            word_count_d = word_count_q + WC_W'(1);
            if (bus.s_last) begin
              state_d      = ST_SETTLE;
              settle_cnt_d = SC_W'(SETTLE_CYC);
            end
          end
`endif
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SC_W'(1)) begin
          state_d    = ST_RUN;
          core_run_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          settle_cnt_d = settle_cnt_q - SC_W'(1);
        end
      end
      ST_RUN, ST_ERROR: begin
        if (reload) begin
          state_d      = ST_IDLE;
          word_count_d = '0;
          core_run_d   = 1'b0;
          done_d       = 1'b0;
          error_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    s_ready_d = (state_d == ST_IDLE) | (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      settle_cnt_q <= '0;
      s_ready_q    <= 1'b1;
      im_write_q   <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      core_run_q   <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      settle_cnt_q <= settle_cnt_d;
      s_ready_q    <= s_ready_d;
      im_write_q   <= im_write_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      core_run_q   <= core_run_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.im_write = im_write_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign core_run     = core_run_q;
  assign done         = done_q;
  assign error        = error_q;
  assign word_count   = word_count_q;
endmodule

// File: tb/tb_im_loader.sv
// Randomised load/reload/reset bench for im_loader against a transaction-level model.
// Honours IM_LOADER_CHECKSUM_EN so the same bench covers both builds.
module tb_im_loader;
  import im_loader_pkg::*;

  localparam int unsigned       DW     = 32;
  localparam int unsigned       AW     = 32;
  localparam int unsigned       DEPTH  = 4;
  localparam int unsigned       SETTLE = 2;
  localparam logic [AW-1:0]     BASE   = 32'd1;
  localparam int unsigned       WC_W   = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            reload = 1'b0;
  logic            core_run, done, error;
  logic [WC_W-1:0] word_count;

  im_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  im_loader #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .reload     (reload),
    .core_run   (core_run),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } wr_t;

  wr_t  got_q[$];
  int   rise_cyc = -1;
  logic run_prev = 1'b0;

  always @(negedge clk) begin
    wr_t w;
    if (rst) begin
      run_prev = 1'b0;
    end else begin
      if (bus.im_write) begin
        w.addr = bus.im_addr;
        w.data = bus.im_wdata;
        w.cyc  = cyc;
        got_q.push_back(w);
      end
      if (core_run && !run_prev) rise_cyc = cyc;
      run_prev = core_run;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_s_ready",  bus.s_ready,  1);
    chk("rst_im_write", bus.im_write, 0);
    chk("rst_im_addr",  bus.im_addr,  0);
    chk("rst_im_wdata", bus.im_wdata, 0);
    chk("rst_core_run", core_run,     0);
    chk("rst_done",     done,         0);
    chk("rst_error",    error,        0);
    chk("rst_wcount",   word_count,   0);
  endtask

  logic [DW-1:0] w_q[$];
  bit            l_q[$];

  // Model: walk the word list by the loader's rules, then drive, observe and compare.
  task automatic run_load(input int max_gap, input bit poke);
    int            cnt = 0;
    int            n_send = 0;
    bit            exp_run = 0;
    bit            term = 0;
    logic [DW-1:0] sum = '0;
    int            idx_wr[$];
    int            pres[$];
    int            g;

    for (int i = 0; i < w_q.size() && !term; i++) begin
      n_send = i + 1;
`ifdef IM_LOADER_CHECKSUM_EN
      if (l_q[i]) begin
        term = 1; exp_run = (w_q[i] == sum);
      end else if (cnt == DEPTH) begin
        term = 1;
      end else begin
        idx_wr.push_back(i); sum = sum + w_q[i]; cnt++;
      end
`else
      if (cnt == DEPTH) begin
        term = 1;
      end else begin
        idx_wr.push_back(i); cnt++;
        if (l_q[i]) begin term = 1; exp_run = 1; end
      end
`endif
    end

    got_q.delete();
    rise_cyc = -1;
    for (int i = 0; i < n_send; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        bus.s_valid = 1'b0;
        reload = poke ? 1'($urandom_range(1, 0)) : 1'b0;
        step();
      end
      reload      = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = w_q[i];
      bus.s_last  = l_q[i];
      chk("s_ready_load", bus.s_ready, 1);
      pres.push_back(cyc);
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = $urandom();
    reload = (exp_run && poke) ? 1'b1 : 1'b0;
    step();
    reload = 1'b0;
    repeat (SETTLE + 4) step();

    chk("n_writes", got_q.size(), idx_wr.size());
    for (int j = 0; j < idx_wr.size() && j < got_q.size(); j++) begin
      chk("wr_addr", got_q[j].addr, BASE + j);
      chk("wr_data", got_q[j].data, w_q[idx_wr[j]]);
      chk("wr_cyc",  got_q[j].cyc,  pres[idx_wr[j]] + 1);
    end
    chk("word_count",  word_count,  cnt);
    chk("core_run",    core_run,    exp_run);
    chk("done",        done,        exp_run);
    chk("error",       error,       !exp_run);
    chk("s_ready_end", bus.s_ready, 0);
    if (exp_run) chk("run_cyc", rise_cyc, pres[n_send-1] + 1 + SETTLE);
    else         chk("no_run",  rise_cyc, -1);

    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("rl_core_run", core_run,    0);
    chk("rl_done",     done,        0);
    chk("rl_error",    error,       0);
    chk("rl_wcount",   word_count,  0);
    chk("rl_s_ready",  bus.s_ready, 1);
  endtask

  task automatic add_word(input logic [DW-1:0] d, input bit last);
    w_q.push_back(d);
    l_q.push_back(last);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    step();
    step();
    chk_reset_vals();
    rst = 1'b0;
    step();
    chk_reset_vals();

`ifdef IM_LOADER_CHECKSUM_EN
    w_q.delete(); l_q.delete();
    add_word(32'h100100B2, 0); add_word(32'h1002000C, 0); add_word(32'h200300BE, 1);
    run_load(0, 0);
    w_q.delete(); l_q.delete();
    add_word(32'h100100B2, 0); add_word(32'h1002000C, 0); add_word(32'h00000000, 1);
    run_load(0, 0);
`else
    w_q.delete(); l_q.delete();
    add_word(32'h100100B2, 0); add_word(32'h1002000C, 1);
    run_load(0, 0);
    w_q.delete(); l_q.delete();
    add_word(32'h100100B2, 0); add_word(32'h1002000C, 1);
    run_load(3, 0);
`endif
    w_q.delete(); l_q.delete();
    for (int i = 0; i <= DEPTH; i++) add_word($urandom(), 0);
    run_load(0, 0);

    for (int t = 0; t < 30; t++) begin
      int            kind;
      int            n;
      logic [DW-1:0] s;
      kind = $urandom_range(3, 0);
      w_q.delete(); l_q.delete();
      if (kind == 0) begin
        for (int i = 0; i < DEPTH; i++) add_word($urandom(), 0);
        add_word($urandom(), 1'($urandom_range(1, 0)));
      end else begin
`ifdef IM_LOADER_CHECKSUM_EN
        n = $urandom_range(DEPTH, 0);
        s = '0;
        for (int i = 0; i < n; i++) begin
          w_q.push_back($urandom()); l_q.push_back(0); s = s + w_q[i];
        end
        add_word($urandom_range(1, 0) ? s : $urandom(), 1);
`else
        n = $urandom_range(DEPTH, 1);
        for (int i = 0; i < n; i++) add_word($urandom(), i == n - 1);
`endif
      end
      run_load(3, 1'($urandom_range(1, 0)));
    end

    bus.s_valid = 1'b1;
    bus.s_data  = 32'hDEADBEEF;
    bus.s_last  = 1'b0;
    step();
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals();
    step();
    rst = 1'b0;
    step();
    w_q.delete(); l_q.delete();
`ifdef IM_LOADER_CHECKSUM_EN
    add_word(32'h0000ABCD, 0); add_word(32'h0000ABCD, 1);
`else
    add_word(32'h0000ABCD, 1);
`endif
    run_load(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
